// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and line/frame start strobes, all advanced by a pixel strobe.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter bit H_POL     = 1'b0,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit V_POL     = 1'b0,
    parameter int HCW       = 10,
    parameter int VCW       = 10
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           pixelEn,
    output logic           hSync,
    output logic           vSync,
    output logic [HCW-1:0] pixelCnt,
    output logic [VCW-1:0] lineCnt,
    output logic           displayActive,
    output logic           compBlank,
    output logic           lineStart,
    output logic           frameStart
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_DISPLAY <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0) begin : gBadHParam
        $error("vga_timing_gen: horizontal timing parameters must be non-zero");
    end
    if (V_DISPLAY <= 0 || V_FRONT <= 0 || V_SYNC <= 0 || V_BACK <= 0) begin : gBadVParam
        $error("vga_timing_gen: vertical timing parameters must be non-zero");
    end
    if (HCW <= 0 || HCW > 30 || H_TOTAL > (1 << HCW)) begin : gBadHcw
        $error("vga_timing_gen: HCW too narrow for H_TOTAL");
    end
    if (VCW <= 0 || VCW > 30 || V_TOTAL > (1 << VCW)) begin : gBadVcw
        $error("vga_timing_gen: VCW too narrow for V_TOTAL");
    end

    localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_VIS_END    = HCW'(H_DISPLAY);
    localparam logic [HCW-1:0] H_SYNC_START = HCW'(H_DISPLAY + H_FRONT);
    localparam logic [HCW-1:0] H_SYNC_END   = HCW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_VIS_END    = VCW'(V_DISPLAY);
    localparam logic [VCW-1:0] V_SYNC_START = VCW'(V_DISPLAY + V_FRONT);
    localparam logic [VCW-1:0] V_SYNC_END   = VCW'(V_DISPLAY + V_FRONT + V_SYNC);

    function automatic logic hSyncLevel(input logic [HCW-1:0] p);
        return (p >= H_SYNC_START && p < H_SYNC_END) ? H_POL : ~H_POL;
    endfunction

    function automatic logic vSyncLevel(input logic [VCW-1:0] l);
        return (l >= V_SYNC_START && l < V_SYNC_END) ? V_POL : ~V_POL;
    endfunction

    function automatic logic inVisible(input logic [HCW-1:0] p, input logic [VCW-1:0] l);
        return (p < H_VIS_END) && (l < V_VIS_END);
    endfunction

    logic           pixWrap;
    logic           lineWrap;
    logic [HCW-1:0] pixelNext;
    logic [VCW-1:0] lineNext;
    logic           activeNext;

    // Next raster position; outputs are decoded from it so they land with the counters.
    always_comb begin
        pixWrap    = (pixelCnt == H_LAST);
        lineWrap   = (lineCnt == V_LAST);
        pixelNext  = pixWrap ? '0 : pixelCnt + HCW'(1);
        lineNext   = lineCnt;
        if (pixWrap) begin
            lineNext = lineWrap ? '0 : lineCnt + VCW'(1);
        end
        activeNext = inVisible(pixelNext, lineNext);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixelCnt      <= '0;
            lineCnt       <= '0;
            hSync         <= ~H_POL;
            vSync         <= ~V_POL;
            displayActive <= 1'b1;
            compBlank     <= 1'b0;
            lineStart     <= 1'b0;
            frameStart    <= 1'b0;
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
            if (pixelEn) begin
                pixelCnt      <= pixelNext;
                lineCnt       <= lineNext;
                hSync         <= hSyncLevel(pixelNext);
                vSync         <= vSyncLevel(lineNext);
                displayActive <= activeNext;
                compBlank     <= ~activeNext;
                lineStart     <= pixWrap;
                frameStart    <= pixWrap && lineWrap;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a scaled-down raster, compared every
// cycle against a linear-position reference model.
module tb_vga_timing_gen;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 10, VF = 2, VS = 2, VB = 3;
    localparam bit HP = 1'b1, VP = 1'b0;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pixelEn = 1'b0;
    logic       hSync, vSync, displayActive, compBlank, lineStart, frameStart;
    logic [4:0] pixelCnt;
    logic [4:0] lineCnt;

    int checks = 0;
    int failures = 0;

    int mPx = 0, mLn = 0;
    bit mLs = 0, mFs = 0;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_POL(HP),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_POL(VP),
        .HCW(5), .VCW(5)
    ) dut (
        .clock(clock), .reset(reset), .pixelEn(pixelEn),
        .hSync(hSync), .vSync(vSync), .pixelCnt(pixelCnt), .lineCnt(lineCnt),
        .displayActive(displayActive), .compBlank(compBlank),
        .lineStart(lineStart), .frameStart(frameStart)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPx = 0; mLn = 0; mLs = 0; mFs = 0;
    endtask

    task automatic checkAll();
        bit expHs, expVs, expAct;
        expHs  = (mPx >= HD + HF && mPx < HD + HF + HS) ? HP : !HP;
        expVs  = (mLn >= VD + VF && mLn < VD + VF + VS) ? VP : !VP;
        expAct = (mPx < HD) && (mLn < VD);
        check("pixelCnt", 32'(pixelCnt), 32'(mPx));
        check("lineCnt", 32'(lineCnt), 32'(mLn));
        check("hSync", 32'(hSync), 32'(expHs));
        check("vSync", 32'(vSync), 32'(expVs));
        check("displayActive", 32'(displayActive), 32'(expAct));
        check("compBlank", 32'(compBlank), 32'(!expAct));
        check("lineStart", 32'(lineStart), 32'(mLs));
        check("frameStart", 32'(frameStart), 32'(mFs));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        int idx;
        @(posedge clock);
        if (reset) begin
            modelReset();
        end else if (pixelEn) begin
            idx = (mLn * HT + mPx + 1) % FRAME;
            mPx = idx % HT;
            mLn = idx / HT;
            mLs = (mPx == 0);
            mFs = (idx == 0);
        end else begin
            mLs = 0;
            mFs = 0;
        end
        #1;
        checkAll();
    endtask

    initial begin
        int fsSeen, fsFirst, fsSecond, actCount, enCount, steps;
        bit found;

        // Reset held over several edges
        repeat (3) step();
        reset = 1'b0;

        // Continuous enable from the released position for two frames
        pixelEn = 1'b1;
        fsSeen = 0; fsFirst = -1; fsSecond = -1; actCount = 0;
        for (int i = 1; i <= 2 * FRAME + 5; i++) begin
            step();
            if (frameStart) begin
                fsSeen++;
                if (fsSeen == 1) fsFirst = i;
                else if (fsSeen == 2) fsSecond = i;
            end
            if (fsSeen == 1 && displayActive) actCount++;
        end
        check("firstFrameStartCycle", 32'(fsFirst), 32'(FRAME));
        check("framePeriod", 32'(fsSecond - fsFirst), 32'(FRAME));
        check("activePerFrame", 32'(actCount), 32'(HD * VD));

        // Random pixel strobe
        for (int i = 0; i < 1500; i++) begin
            pixelEn = 1'($urandom_range(0, 1));
            step();
        end

        // Asynchronous reset mid-frame, checked before the next edge
        pixelEn = 1'b1;
        steps = $urandom_range(150, 300);
        for (int i = 0; i < steps; i++) step();
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        repeat (2) step();
        reset = 1'b0;

        // Next frameStart must come exactly one frame of enabled edges later
        enCount = 0;
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            pixelEn = 1'($urandom_range(0, 3) != 0);
            step();
            if (pixelEn) enCount++;
            if (frameStart) found = 1;
        end
        check("frameStartFound", 32'(found), 32'(1));
        check("enabledCyclesToFrame", 32'(enCount), 32'(FRAME));

        // Random strobe again, including the wrap corner many times
        for (int i = 0; i < 1500; i++) begin
            pixelEn = 1'($urandom_range(0, 4) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync pulse width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter H_POL, 0, hSync asserted level.
REQ-006 Parameters V_DISPLAY, V_FRONT, V_SYNC, V_BACK, V_POL, defaults 480, 10, 2, 33, 0: vertical equivalents, in lines.
REQ-007 Parameters HCW and VCW, defaults 10 and 10: counter widths; each SHALL be at least clog2(total).
REQ-008 clock  input  1  single clock; all state updates on its rising edge.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 pixelEn  input  1  pixel strobe; counters advance only on cycles with pixelEn=1.
REQ-011 hSync, vSync  output  1 each  sync outputs, polarity set by H_POL/V_POL.
REQ-012 pixelCnt  output  HCW  horizontal position, 0..H_TOTAL-1.
REQ-013 lineCnt  output  VCW  vertical position, 0..V_TOTAL-1.
REQ-014 displayActive  output  1  high when both counters are inside the visible region.
REQ-015 compBlank  output  1  inverse of displayActive.
REQ-016 lineStart, frameStart  output  1 each  single-cycle strobes.

Function
REQ-017 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL is the vertical equivalent; both SHALL be computed at elaboration.
REQ-018 pixelCnt SHALL increment on each pixelEn=1 cycle and wrap from H_TOTAL-1 to 0.
REQ-019 lineCnt SHALL increment only on a pixelEn=1 cycle with pixelCnt=H_TOTAL-1, and wrap from V_TOTAL-1 to 0 on that same event.
REQ-020 With pixelEn=0, the counters and all outputs SHALL hold their values, except that strobes SHALL be 0.
REQ-021 hSync SHALL equal H_POL while H_DISPLAY+H_FRONT <= pixelCnt < H_DISPLAY+H_FRONT+H_SYNC, and ~H_POL otherwise.
REQ-022 vSync SHALL equal V_POL while V_DISPLAY+V_FRONT <= lineCnt < V_DISPLAY+V_FRONT+V_SYNC, and ~V_POL otherwise.
REQ-023 displayActive SHALL be 1 iff pixelCnt < H_DISPLAY and lineCnt < V_DISPLAY.
REQ-024 hSync, vSync, displayActive and compBlank SHALL be registered and cycle-aligned with the pixelCnt/lineCnt values they describe (zero skew between outputs).
REQ-025 lineStart SHALL be 1 for exactly one clock, in the cycle where pixelCnt has just become 0 via wrap.
REQ-026 frameStart SHALL be 1 for exactly one clock, in the cycle where pixelCnt and lineCnt have both just become 0 via wrap; lineStart SHALL also be 1 in that cycle.
REQ-027 No output SHALL glitch; all outputs SHALL be flop-driven.
REQ-028 Any parameter of 0 SHALL be rejected at elaboration; so SHALL any total that exceeds its counter width.

Reset
REQ-029 While reset=1: pixelCnt=0, lineCnt=0, hSync=~H_POL, vSync=~V_POL, displayActive=1, compBlank=0, lineStart=0, frameStart=0.
REQ-030 Reset asserted mid-line or mid-frame SHALL force the REQ-029 values immediately, without waiting for a clock edge.
REQ-031 After reset deasserts, the first pixelEn=1 edge SHALL advance pixelCnt to 1; no strobe SHALL fire for the reset-released position 0,0.

Verification
REQ-032 Defaults, pixelEn=1 constant, 2 frames -> each line 800 clocks with hSync low for pixelCnt 656..751; each frame 420000 clocks with vSync low for lineCnt 490..491.
REQ-033 pixelEn toggling 1,0,1,0 -> pixelCnt advances once per two clocks; strobes are never wider than one clock; the frame is 840000 clocks.
REQ-034 Defaults -> displayActive is high for exactly 307200 pixelEn cycles per frame; compBlank equals ~displayActive on every cycle.
REQ-035 Reset pulsed at pixelCnt=700, lineCnt=300 -> outputs take the REQ-029 values asynchronously; the next frameStart occurs 420000 enabled cycles after release.
REQ-036 Override H_POL=1, V_POL=1 with 800x600 timing (40/128/88, 1/4/23) -> hSync high for pixelCnt 840..967; line 1056 clocks; frame 628 lines.
REQ-037 Wrap corner, pixelCnt=799 and lineCnt=524 with pixelEn=1 -> next cycle both are 0, frameStart=1, lineStart=1, displayActive=1.
